// File: rtl/beta_mem_arbiter.sv
// Shares the single memory port between instruction fetch and load/store data.
// Data has fixed priority, but fetch wins after DATA_STREAK_MAX data grants in a row.
`timescale 1ns/1ps
module beta_mem_arbiter #(
  parameter int unsigned XLEN            = 32,
  parameter int unsigned DATA_STREAK_MAX = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              instr_req_i,
  input  logic [XLEN-1:0]   instr_addr_i,
  output logic              instr_gnt_o,
  output logic              instr_rvalid_o,
  output logic [XLEN-1:0]   instr_rdata_o,
  output logic              instr_err_o,
  input  logic              data_req_i,
  input  logic              data_we_i,
  input  logic [XLEN/8-1:0] data_be_i,
  input  logic [XLEN-1:0]   data_addr_i,
  input  logic [XLEN-1:0]   data_wdata_i,
  output logic              data_gnt_o,
  output logic              data_rvalid_o,
  output logic [XLEN-1:0]   data_rdata_o,
  output logic              data_err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [XLEN/8-1:0] mem_be_o,
  output logic [XLEN-1:0]   mem_addr_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [XLEN-1:0]   mem_rdata_i,
  input  logic              mem_err_i
);

  localparam int unsigned      StreakW   = $clog2(DATA_STREAK_MAX + 1);
  localparam logic [StreakW-1:0] StreakMax = StreakW'(DATA_STREAK_MAX);

  typedef enum logic [1:0] {StIdle, StWaitGnt, StWaitResp} state_e;

  state_e               state_q, state_d;
  logic                 owner_q, owner_d;
  logic [StreakW-1:0]   streak_q, streak_d;

  logic w_instr_force, w_sel_data, w_owner, w_req, w_gnt, w_resp;

  always_comb begin
    w_instr_force = data_req_i && instr_req_i && (streak_q == StreakMax);
    w_sel_data    = data_req_i && !w_instr_force;
    // Owner is only re-arbitrated in idle; afterwards it is locked in owner_q.
    w_owner       = (state_q == StIdle) ? w_sel_data : owner_q;
    w_req         = rst_ni && ((state_q == StIdle) ? (data_req_i || instr_req_i)
                                                   : (state_q == StWaitGnt));
    w_gnt         = w_req && mem_gnt_i;
    w_resp        = rst_ni && (state_q == StWaitResp) && mem_rvalid_i;
  end

  always_comb begin
    mem_req_o   = w_req;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (w_req) begin
      if (w_owner) begin
        mem_we_o    = data_we_i;
        mem_be_o    = data_be_i;
        mem_addr_o  = data_addr_i;
        mem_wdata_o = data_wdata_i;
      end else begin
        mem_be_o    = '1;
        mem_addr_o  = instr_addr_i;
      end
    end
    instr_gnt_o    = w_gnt && !w_owner;
    data_gnt_o     = w_gnt && w_owner;
    instr_rvalid_o = w_resp && !owner_q;
    data_rvalid_o  = w_resp && owner_q;
    instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : '0;
    instr_err_o    = instr_rvalid_o && mem_err_i;
    data_rdata_o   = data_rvalid_o ? mem_rdata_i : '0;
    data_err_o     = data_rvalid_o && mem_err_i;
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    streak_d = streak_q;
    unique case (state_q)
      StIdle: begin
        if (w_req) begin
          owner_d = w_sel_data;
          state_d = mem_gnt_i ? StWaitResp : StWaitGnt;
        end
      end
      StWaitGnt:  if (mem_gnt_i) state_d = StWaitResp;
      StWaitResp: if (mem_rvalid_i) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
    if (w_gnt) begin
      if (w_owner && instr_req_i) begin
        streak_d = (streak_q == StreakMax) ? streak_q : streak_q + 1'b1;
      end else begin
        streak_d = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      owner_q  <= 1'b0;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      streak_q <= streak_d;
    end
  end

  // A response outside WAIT_RESP is a memory-side protocol violation; it is dropped.
  always @(posedge clk_i) begin
    assert (!(rst_ni && mem_rvalid_i && (state_q != StWaitResp)))
      else $warning("protocol: mem_rvalid_i outside WAIT_RESP, dropped");
  end

endmodule

// File: tb/tb_beta_mem_arbiter.sv
// Randomized scoreboard bench for beta_mem_arbiter: two requester processes, a memory
// model, and a monitor checking arbitration order, payload forwarding and responses.
`timescale 1ns/1ps
module tb_beta_mem_arbiter;

  localparam int SM = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        instr_req_i = 1'b0;
  logic [31:0] instr_addr_i = '0;
  logic        instr_gnt_o, instr_rvalid_o, instr_err_o;
  logic [31:0] instr_rdata_o;
  logic        data_req_i = 1'b0, data_we_i = 1'b0;
  logic [3:0]  data_be_i = '0;
  logic [31:0] data_addr_i = '0, data_wdata_i = '0;
  logic        data_gnt_o, data_rvalid_o, data_err_o;
  logic [31:0] data_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0, mem_err_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;

  beta_mem_arbiter #(.XLEN(32), .DATA_STREAK_MAX(SM)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
    .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i)
  );

  always #5 clk_i = ~clk_i;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [32:0] q_i[$];      // expected {err, rdata} per requester
  logic [32:0] q_d[$];
  bit          gorder[$];   // 1 = data granted, 0 = instr granted
  logic [31:0] ref_ram[16]; // requester-side view of data memory
  logic [31:0] bus_ram[16]; // memory-side storage
  int          lat_force = -1;
  logic        mem_pend = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic err_of(input logic [31:0] a);
    return a[4:2] == 3'd5;
  endfunction

  task automatic instr_proc(input int n, input int max_gap);
    for (int k = 0; k < n; k++) begin
      int          t;
      logic [31:0] a;
      repeat ($urandom_range(max_gap, 0)) begin @(posedge clk_i); #1; end
      a = 32'($urandom_range(63, 0)) * 4;
      q_i.push_back({err_of(a), rom(a)});
      instr_req_i = 1'b1; instr_addr_i = a;
      t = 0;
      do begin @(negedge clk_i); t++; end while (!instr_gnt_o && t < 300);
      if (!instr_gnt_o) chk("instr_gnt_timeout", 64'd0, 64'd1);
      @(posedge clk_i); #1;
      instr_req_i = 1'b0;
    end
  endtask

  task automatic data_proc(input int n, input int max_gap);
    for (int k = 0; k < n; k++) begin
      int          t;
      logic [31:0] a, wd;
      logic        we;
      logic [3:0]  be;
      repeat ($urandom_range(max_gap, 0)) begin @(posedge clk_i); #1; end
      a  = 32'h100 + 32'($urandom_range(15, 0)) * 4;
      we = 1'($urandom_range(1, 0));
      be = we ? 4'($urandom_range(15, 1)) : 4'hF;
      wd = $urandom;
      if (we) begin
        for (int b = 0; b < 4; b++) if (be[b]) ref_ram[a[5:2]][8*b +: 8] = wd[8*b +: 8];
        q_d.push_back({err_of(a), 32'h0});
      end else begin
        q_d.push_back({err_of(a), ref_ram[a[5:2]]});
      end
      data_req_i = 1'b1; data_we_i = we; data_be_i = be; data_addr_i = a; data_wdata_i = wd;
      t = 0;
      do begin @(negedge clk_i); t++; end while (!data_gnt_o && t < 300);
      if (!data_gnt_o) chk("data_gnt_timeout", 64'd0, 64'd1);
      @(posedge clk_i); #1;
      data_req_i = 1'b0;
    end
  endtask

  // Memory side: random grant stalls, 1..4 cycle response latency.
  initial begin : mem_model
    int          lat;
    logic [31:0] c_addr;
    logic        c_we;
    lat = 0; c_addr = '0; c_we = 1'b0;
    forever begin
      @(negedge clk_i);
      if (mem_rvalid_i) mem_pend = 1'b0;
      if (mem_req_o && mem_gnt_i) begin
        c_addr = mem_addr_o; c_we = mem_we_o;
        if (c_we && c_addr >= 32'h100)
          for (int b = 0; b < 4; b++)
            if (mem_be_o[b]) bus_ram[c_addr[5:2]][8*b +: 8] = mem_wdata_o[8*b +: 8];
        mem_pend = 1'b1;
        lat = (lat_force >= 0) ? lat_force : int'($urandom_range(3, 0));
      end
      @(posedge clk_i); #1;
      mem_rvalid_i = 1'b0; mem_err_i = 1'b0; mem_rdata_i = '0;
      mem_gnt_i = ($urandom_range(1, 0) == 1);
      if (mem_pend) begin
        if (lat == 0) begin
          mem_rvalid_i = 1'b1;
          mem_err_i    = err_of(c_addr);
          mem_rdata_i  = c_we ? 32'h0 : (c_addr >= 32'h100) ? bus_ram[c_addr[5:2]] : rom(c_addr);
        end else begin
          lat--;
        end
      end
    end
  end

  initial begin : monitor
    logic     locked, exp_own, outst, own_q;
    int       streak;
    logic [32:0] e;
    locked = 0; exp_own = 0; outst = 0; own_q = 0; streak = 0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        chk("reset_outputs_zero", 64'(|{instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
            data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o, mem_req_o, mem_we_o,
            mem_be_o, mem_addr_o, mem_wdata_o}), 64'd0);
        locked = 0; outst = 0; streak = 0;
        q_i.delete(); q_d.delete();
      end else begin
        if (mem_rvalid_i && outst) begin
          chk("rvalid_route", {instr_rvalid_o, data_rvalid_o}, own_q ? 2'b01 : 2'b10);
          if (own_q) begin
            chk("data_resp_queued", 64'(q_d.size() > 0), 64'd1);
            if (q_d.size() > 0) begin
              e = q_d.pop_front();
              chk("data_rdata_err", {data_err_o, data_rdata_o}, e);
            end
            chk("instr_quiet", {instr_err_o, instr_rdata_o}, 64'd0);
          end else begin
            chk("instr_resp_queued", 64'(q_i.size() > 0), 64'd1);
            if (q_i.size() > 0) begin
              e = q_i.pop_front();
              chk("instr_rdata_err", {instr_err_o, instr_rdata_o}, e);
            end
            chk("data_quiet", {data_err_o, data_rdata_o}, 64'd0);
          end
          outst = 0;
        end else begin
          chk("no_rvalid", {instr_rvalid_o, data_rvalid_o}, 64'd0);
          if (outst) chk("no_req_while_outstanding", 64'(mem_req_o), 64'd0);
        end
        if (mem_req_o && !locked) begin
          exp_own = (data_req_i && instr_req_i && streak == SM) ? 1'b0 : data_req_i;
          chk("owner_select", 64'(mem_addr_o >= 32'h100), 64'(exp_own));
          locked = 1;
        end
        if (mem_req_o && locked) begin
          if (exp_own) begin
            chk("data_payload", {mem_addr_o, mem_wdata_o}, {data_addr_i, data_wdata_i});
            chk("data_we_be", {mem_we_o, mem_be_o}, {data_we_i, data_be_i});
          end else begin
            chk("instr_payload", {mem_we_o, mem_be_o, mem_addr_o}, {1'b0, 4'hF, instr_addr_i});
          end
        end
        if (mem_req_o && mem_gnt_i) begin
          chk("gnt_pulse", {instr_gnt_o, data_gnt_o}, exp_own ? 2'b01 : 2'b10);
          streak = (exp_own && instr_req_i) ? ((streak < SM) ? streak + 1 : SM) : 0;
          gorder.push_back(exp_own);
          locked = 0; outst = 1; own_q = exp_own;
        end else begin
          chk("no_gnt", {instr_gnt_o, data_gnt_o}, 64'd0);
        end
      end
    end
  end

  task automatic drain();
    int t = 0;
    while ((q_i.size() > 0 || q_d.size() > 0 || mem_pend) && t < 500) begin
      @(posedge clk_i); t++;
    end
    #1;
    if (t >= 500) chk("drain_timeout", 64'd0, 64'd1);
  endtask

  task automatic do_reset(input int cycles);
    rst_ni = 1'b0;
    repeat (cycles) begin @(posedge clk_i); #1; end
    rst_ni = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      ref_ram[i] = (32'(i) * 32'h0101_0101) ^ 32'hC0DE_0000;
      bus_ram[i] = ref_ram[i];
    end
    rst_ni = 1'b1;
    #3;
    // Requests held high during reset must not leak to any output.
    instr_req_i = 1'b1; instr_addr_i = 32'h40;
    data_req_i = 1'b1; data_we_i = 1'b1; data_be_i = 4'hF; data_addr_i = 32'h104;
    data_wdata_i = 32'h1234_5678;
    do_reset(3);
    instr_req_i = 1'b0; data_req_i = 1'b0;

    fork
      instr_proc(40, 3);
      data_proc(40, 3);
    join
    drain();

    // Both requesters held high continuously: D,D,D,D,I,D,D,D,D,I.
    do_reset(2);
    gorder.delete();
    fork
      instr_proc(2, 0);
      data_proc(8, 0);
    join
    drain();
    for (int i = 0; i < 10; i++)
      chk($sformatf("grant_order[%0d]", i), (gorder.size() > i) ? 64'(gorder[i]) : 64'hBAD,
          (i % 5 == 4) ? 64'd0 : 64'd1);

    // Reset while the data response is outstanding; the late response must be dropped.
    lat_force = 12;
    data_proc(1, 0);
    @(posedge clk_i); #1;
    rst_ni = 1'b0;
    instr_req_i = 1'b1; instr_addr_i = 32'h80; data_req_i = 1'b1;
    repeat (2) begin @(posedge clk_i); #1; end
    rst_ni = 1'b1;
    instr_req_i = 1'b0; data_req_i = 1'b0;
    drain();
    lat_force = -1;
    instr_proc(2, 0);
    drain();
    repeat (3) @(posedge clk_i);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
